// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM states, arbitration
// mode codes and the grant index width.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Grant index width; a single channel still needs one bit.
  function automatic int grant_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Rotating-priority picker: first requester at or after start, wrapping.
// With mode clear the search always starts at channel 0 (fixed priority).
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int GW     = grant_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [GW-1:0]     start,
  input  logic              mode,
  output logic              valid,
  output logic [GW-1:0]     idx
);

  int          base;
  logic [GW-1:0] cand;

  // Walk offsets from the far end so the nearest requester is written last.
  always_comb begin
    base  = mode ? int'(start) : 0;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = GW'((base + off) % NUM_CH);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one sram-style port between core requesters;
// each request is latched, issued, and completed by a one-cycle ack or timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int ARB_MODE = 0,
  parameter  int TIMEOUT  = 255,
  localparam int MASK_W   = DATA_W / 8,
  localparam int GW       = grant_w(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_sel,
  input  logic [NUM_CH-1:0]          ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH*MASK_W-1:0]   ch_wmask,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [NUM_CH-1:0]          ch_err,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_sel,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_din,
  output logic [MASK_W-1:0]          mem_byte_en,
  input  logic [DATA_W-1:0]          mem_dout,
  input  logic                       mem_ack
);

  state_t              state, nxt;
  logic [GW-1:0]       gnt_q, rr_ptr, start, pick_idx;
  logic                pick_vld;
  logic                we_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [31:0]         cnt_q;
  logic                timeout_hit;

  // Round-robin search begins one past the last winner.
  assign start = (rr_ptr == GW'(NUM_CH - 1)) ? '0 : rr_ptr + 1'b1;

  arb_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (ch_sel),
    .start (start),
    .mode  (ARB_MODE != ARB_FIXED),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // mem_ack wins over a same-cycle timeout.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pick_vld) nxt = BUSY;
      BUSY:    if (mem_ack || timeout_hit) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      rr_ptr  <= GW'(NUM_CH - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          gnt_q   <= pick_idx;
          rr_ptr  <= pick_idx;
          we_q    <= ch_we[pick_idx];
          addr_q  <= ch_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_q <= ch_wdata[pick_idx*DATA_W +: DATA_W];
          wmask_q <= ch_wmask[pick_idx*MASK_W +: MASK_W];
          cnt_q   <= '0;
        end
        BUSY: begin
          if (mem_ack) begin
            rdata_q <= we_q ? '0 : mem_dout;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory side is live only in BUSY; channel side only in DONE.
  always_comb begin
    mem_sel     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    mem_byte_en = '0;
    ch_ack      = '0;
    ch_err      = '0;
    ch_rdata    = '0;
    if (state == BUSY) begin
      mem_sel     = 1'b1;
      mem_we      = we_q;
      mem_addr    = addr_q;
      mem_din     = wdata_q;
      mem_byte_en = wmask_q;
    end
    if (state == DONE) begin
      ch_ack[gnt_q] = 1'b1;
      ch_err[gnt_q] = err_q;
      ch_rdata      = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance share
// stimulus; a transaction-level model is compared every cycle.
module tb_mem_arbiter;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     ch_sel = '0;
  logic [NC-1:0]     ch_we = '0;
  logic [NC*AW-1:0]  ch_addr = '0;
  logic [NC*DW-1:0]  ch_wdata = '0;
  logic [NC*MW-1:0]  ch_wmask = '0;
  logic [DW-1:0]     mem_dout = '0;
  logic              mem_en = 1'b0;
  logic              ack_force = 1'b0;
  wire               mem_ack;

  logic [NC-1:0]     ch_ack [2];
  logic [NC-1:0]     ch_err [2];
  logic [DW-1:0]     ch_rdata [2];
  logic              mem_sel [2];
  logic              mem_we [2];
  logic [AW-1:0]     mem_addr [2];
  logic [DW-1:0]     mem_din [2];
  logic [MW-1:0]     mem_byte_en [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Single-cycle memory: acks whatever cycle it sees a select, unless disabled.
  assign mem_ack = (mem_en & mem_sel[0]) | ack_force;

  mem_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(TO)) dut_f (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_wmask(ch_wmask), .ch_ack(ch_ack[0]), .ch_err(ch_err[0]),
    .ch_rdata(ch_rdata[0]), .mem_sel(mem_sel[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_byte_en(mem_byte_en[0]),
    .mem_dout(mem_dout), .mem_ack(mem_ack));

  mem_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(TO)) dut_r (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_wmask(ch_wmask), .ch_ack(ch_ack[1]), .ch_err(ch_err[1]),
    .ch_rdata(ch_rdata[1]), .mem_sel(mem_sel[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_byte_en(mem_byte_en[1]),
    .mem_dout(mem_dout), .mem_ack(mem_ack));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One transaction at a time: granted, then in flight for some cycles,
  // then one completion cycle. Both instances share that timing.
  bit          in_flight = 0, completing = 0, m_err = 0;
  int          age = 0, rr_last = NC - 1;
  int          g_m [2];
  bit          we_m [2];
  logic [31:0] addr_m [2], wd_m [2], rd_m [2];
  logic [3:0]  be_m [2];

  function automatic bit req_of(input logic [NC-1:0] s, input int k);
    return ((s >> k) & NC'(1)) != 0;
  endfunction

  function automatic int lowest(input logic [NC-1:0] s);
    for (int i = 0; i < NC; i++) if (req_of(s, i)) return i;
    return 0;
  endfunction

  function automatic int after_last(input logic [NC-1:0] s, input int p);
    for (int o = 1; o <= NC; o++) if (req_of(s, (p + o) % NC)) return (p + o) % NC;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight = 0; completing = 0; m_err = 0; age = 0; rr_last = NC - 1;
      for (int m = 0; m < 2; m++) begin
        g_m[m] = 0; we_m[m] = 0; addr_m[m] = 0; wd_m[m] = 0; rd_m[m] = 0; be_m[m] = 0;
      end
    end else if (completing) begin
      completing = 0;
    end else if (in_flight) begin
      if (mem_ack) begin
        for (int m = 0; m < 2; m++) rd_m[m] = we_m[m] ? 32'h0 : mem_dout;
        m_err = 0; in_flight = 0; completing = 1;
      end else if (TO != 0 && age == TO - 1) begin
        for (int m = 0; m < 2; m++) rd_m[m] = 32'h0;
        m_err = 1; in_flight = 0; completing = 1;
      end else begin
        age++;
      end
    end else if (ch_sel != 0) begin
      g_m[0] = lowest(ch_sel);
      g_m[1] = after_last(ch_sel, rr_last);
      rr_last = g_m[1];
      for (int m = 0; m < 2; m++) begin
        we_m[m]   = req_of(ch_we, g_m[m]);
        addr_m[m] = ch_addr[g_m[m]*AW +: AW];
        wd_m[m]   = ch_wdata[g_m[m]*DW +: DW];
        be_m[m]   = ch_wmask[g_m[m]*MW +: MW];
      end
      age = 0; in_flight = 1;
    end
  end

  // Ack order log and first-write capture for the directed checks.
  int          ord_f[$], ord_r[$];
  bit          wr_seen = 0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_din = '0;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [NC-1:0] e_ack;
      e_ack = completing ? (NC'(1) << g_m[m]) : '0;
      chk($sformatf("mem_sel%0d", m), mem_sel[m], in_flight);
      chk($sformatf("mem_we%0d", m), mem_we[m], in_flight & we_m[m]);
      chk($sformatf("mem_addr%0d", m), mem_addr[m], in_flight ? addr_m[m] : 32'h0);
      chk($sformatf("mem_din%0d", m), mem_din[m], in_flight ? wd_m[m] : 32'h0);
      chk($sformatf("mem_be%0d", m), mem_byte_en[m], in_flight ? be_m[m] : 4'h0);
      chk($sformatf("ch_ack%0d", m), ch_ack[m], e_ack);
      chk($sformatf("ch_err%0d", m), ch_err[m], m_err ? e_ack : '0);
      chk($sformatf("ch_rdata%0d", m), ch_rdata[m], completing ? rd_m[m] : 32'h0);
    end
    if (ch_ack[0] != 0) ord_f.push_back(ch_ack[0][1] ? 1 : 0);
    if (ch_ack[1] != 0) ord_r.push_back(ch_ack[1][1] ? 1 : 0);
    if (mem_we[1] && !wr_seen) begin
      wr_seen = 1; wr_be = mem_byte_en[1]; wr_din = mem_din[1];
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_r [4] = '{0, 1, 0, 1};

  initial begin
    repeat (2) step();
    rst = 1'b0;
    step();

    // Single read on ch0 from a one-cycle memory.
    ch_sel = 2'b01; ch_we = 2'b00; ch_addr[0 +: AW] = 32'h10;
    mem_dout = 32'hDEADBEEF; mem_en = 1'b1;
    step();
    chk("t1_sel_c1", mem_sel[0], 1'b1);
    chk("t1_addr_c1", mem_addr[0], 32'h10);
    step();
    chk("t1_ack_f", ch_ack[0], 2'b01);
    chk("t1_ack_r", ch_ack[1], 2'b01);
    chk("t1_rdata", ch_rdata[0], 32'hDEADBEEF);
    chk("t1_err", ch_err[0], 2'b00);
    ch_sel = 2'b00;
    step();

    // Both channels request continuously; fresh reset so round-robin starts at ch0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ord_f.delete(); ord_r.delete();
    ch_sel = 2'b11; ch_we = 2'b10;
    ch_addr[0 +: AW] = 32'h20; ch_addr[AW +: AW] = 32'h24;
    ch_wdata[DW +: DW] = 32'h1234ABCD; ch_wmask[MW +: MW] = 4'b0011;
    mem_dout = 32'h0BADF00D;
    repeat (12) step();
    ch_sel = 2'b00;
    repeat (2) step();
    chk("fix_n", ord_f.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fix_ord%0d", i), ord_f[i], 0);
    chk("rr_n", ord_r.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_ord%0d", i), ord_r[i], exp_r[i]);
    chk("wr_seen", wr_seen, 1'b1);
    chk("wr_be", wr_be, 4'b0011);
    chk("wr_din", wr_din, 32'h1234ABCD);

    // mem_ack with nothing pending must be ignored.
    ack_force = 1'b1;
    repeat (3) begin
      step();
      chk("idle_ack", ch_ack[0], 2'b00);
      chk("idle_sel", mem_sel[1], 1'b0);
    end
    ack_force = 1'b0;

    // Timeout on ch1; ch0 and its address change while the read is in flight.
    mem_en = 1'b0; ch_we = 2'b00;
    ch_sel = 2'b10; ch_addr[AW +: AW] = 32'h30;
    step();
    chk("to_sel_c1", mem_sel[0], 1'b1);
    step();
    ch_sel = 2'b11; ch_addr[0 +: AW] = 32'h44;
    step();
    chk("to_addr_f", mem_addr[0], 32'h30);
    chk("to_addr_r", mem_addr[1], 32'h30);
    step();
    chk("to_noack_c4", ch_ack[0], 2'b00);
    step();
    chk("to_ack_f", ch_ack[0], 2'b10);
    chk("to_err_f", ch_err[0], 2'b10);
    chk("to_ack_r", ch_ack[1], 2'b10);
    chk("to_rdata", ch_rdata[1], 32'h0);
    ch_sel = 2'b00;
    step();
    chk("to_idle", mem_sel[0], 1'b0);

    // Reset in the middle of an in-flight read, then round-robin restarts at ch0.
    ch_sel = 2'b10; ch_addr[0 +: AW] = 32'h50;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_sel", mem_sel[1], 1'b0);
    chk("rst_addr", mem_addr[1], 32'h0);
    chk("rst_ack", ch_ack[1], 2'b00);
    ch_sel = 2'b00;
    step();
    rst = 1'b0;
    ch_sel = 2'b11; mem_en = 1'b1; mem_dout = 32'hCAFE0001;
    step();
    chk("post_rst_addr", mem_addr[1], 32'h50);
    step();
    chk("post_rst_ack", ch_ack[1], 2'b01);
    chk("post_rst_rdata", ch_rdata[1], 32'hCAFE0001);
    ch_sel = 2'b00;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
